// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: drives one active-low row at a time, samples the columns and debounces every key.
// Latency: row period SETTLE_CYCLES+1+COLS cycles; a key changes state after DEBOUNCE_SCANS differing frames.
// Backpressure: none; events are one-cycle pulses serialized one column per REPORT cycle, so none are dropped.
module key_matrix_scanner #(
    parameter int ROWS           = 6,
    parameter int COLS           = 6,
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [ROWS-1:0]      o_GPIO_ROW,
    input  logic [COLS-1:0]      i_GPIO_COL,
    output logic [ROWS*COLS-1:0] o_sound_number,
    output logic                 o_key_event,
    output logic [5:0]           o_key_index,
    output logic                 o_key_press,
    output logic                 o_scan_done
);
    localparam int NKEYS = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW    = $clog2(SETTLE_CYCLES);
    localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [RW-1:0]  LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CLW-1:0] LAST_COL    = CLW'(COLS - 1);
    localparam logic [SW-1:0]  LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [CLW-1:0]   col_q, col_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [COLS-1:0]  sync1_q, sync2_q;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [NKEYS-1:0] changed_q, changed_d;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [ROWS-1:0]  gpio_row_q, gpio_row_d;
    logic             key_event_q, key_event_d;
    logic [5:0]       key_index_q, key_index_d;
    logic             key_press_q, key_press_d;
    logic             scan_done_q, scan_done_d;

    logic [COLS-1:0]  col_raw;
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_in_row;

    // Columns are pulled up, so a closed contact reads as a synchronized 0.
    assign col_raw = ~sync2_q;

    // Per-key view of the current row: its raw column level and whether it belongs to row_idx_q.
    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        assign key_raw[g]    = col_raw[g % COLS];
        assign key_in_row[g] = (row_idx_q == RW'(g / COLS));
    end

    // State register, synchronizer and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SETTLE;
            row_idx_q   <= '0;
            col_q       <= '0;
            settle_q    <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            stable_q    <= '0;
            changed_q   <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
            gpio_row_q  <= '1;
            key_event_q <= 1'b0;
            key_index_q <= '0;
            key_press_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_q       <= col_d;
            settle_q    <= settle_d;
            sync1_q     <= i_GPIO_COL;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            changed_q   <= changed_d;
            cnt_q       <= cnt_d;
            gpio_row_q  <= gpio_row_d;
            key_event_q <= key_event_d;
            key_index_q <= key_index_d;
            key_press_q <= key_press_d;
            scan_done_q <= scan_done_d;
        end
    end

    // Sequencer: SETTLE counts while the row is actually driven, then one SAMPLE, then COLS REPORT cycles.
    // Right after reset the row register is still all ones, so the settle count waits one cycle for the drive.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_d     = col_q;
        settle_d  = settle_q;
        case (state_q)
            ST_SETTLE: begin
                if (!(&gpio_row_q)) begin
                    if (settle_q == LAST_SETTLE) begin
                        settle_d = '0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            ST_SAMPLE: begin
                col_d   = '0;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (col_q == LAST_COL) begin
                    col_d     = '0;
                    state_d   = ST_SETTLE;
                    row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    // Debounce update for the keys of the current row, applied only in the SAMPLE cycle.
    always_comb begin
        stable_d  = stable_q;
        changed_d = changed_q;
        cnt_d     = cnt_q;
        if (state_q == ST_SAMPLE) begin
            for (int k = 0; k < NKEYS; k++) begin
                if (key_in_row[k]) begin
                    if (key_raw[k] == stable_q[k]) begin
                        cnt_d[k]     = '0;
                        changed_d[k] = 1'b0;
                    end else if (int'(cnt_q[k]) + 1 == DEBOUNCE_SCANS) begin
                        stable_d[k]  = key_raw[k];
                        cnt_d[k]     = '0;
                        changed_d[k] = 1'b1;
                    end else begin
                        cnt_d[k]     = cnt_q[k] + 1'b1;
                        changed_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Registered outputs follow the next state: row drive, one event per REPORT column, end-of-frame pulse.
    always_comb begin
        gpio_row_d  = '1;
        key_event_d = 1'b0;
        key_index_d = key_index_q;
        key_press_d = key_press_q;
        scan_done_d = 1'b0;
        if (state_d != ST_REPORT) begin
            gpio_row_d = ~(ROWS'(1) << row_idx_d);
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                if (key_in_row[k] && (col_d == CLW'(k % COLS)) && changed_d[k]) begin
                    key_event_d = 1'b1;
                    key_index_d = 6'(k);
                    key_press_d = stable_d[k];
                end
            end
            scan_done_d = (col_d == LAST_COL) && (row_idx_d == LAST_ROW);
        end
    end

    assign o_GPIO_ROW     = gpio_row_q;
    assign o_sound_number = stable_q;
    assign o_key_event    = key_event_q;
    assign o_key_index    = key_index_q;
    assign o_key_press    = key_press_q;
    assign o_scan_done    = scan_done_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a contact-map matrix model drives the columns, a frame-level
// debounce model predicts held keys and events, and hand sequences cover the multi-frame cases.
module tb_key_matrix_scanner;
    localparam int ROWS   = 6;
    localparam int COLS   = 6;
    localparam int SETTLE = 64;
    localparam int DEB    = 4;
    localparam int NK     = ROWS * COLS;
    localparam int RP     = SETTLE + 1 + COLS;   // row period
    localparam int FP     = ROWS * RP;           // frame period

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [ROWS-1:0] gpio_row;
    logic [COLS-1:0] gpio_col;
    logic [NK-1:0]   sound;
    logic            key_event;
    logic [5:0]      key_index;
    logic            key_press;
    logic            scan_done;

    logic [NK-1:0]   contacts = '0;
    logic            force_en = 1'b1;
    logic [COLS-1:0] force_val = '1;

    always #5 clk = ~clk;

    // Matrix: a closed contact pulls its column low while its row is driven low.
    always_comb begin
        gpio_col = '1;
        if (force_en) begin
            gpio_col = force_val;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (!gpio_row[r] && contacts[r*COLS+c]) gpio_col[c] = 1'b0;
        end
    end

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .o_GPIO_ROW     (gpio_row),
        .i_GPIO_COL     (gpio_col),
        .o_sound_number (sound),
        .o_key_event    (key_event),
        .o_key_index    (key_index),
        .o_key_press    (key_press),
        .o_scan_done    (scan_done)
    );

    typedef struct { int t; int idx; bit press; } ev_t;
    typedef struct { int r; int c; logic [5:0] idx; logic [NK-1:0] bitmap; } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            n = -1;          // cycles since the first edge after reset release
    logic [NK-1:0] mstable;
    int            mrun [NK];
    bit            exp_evt [COLS];
    bit            exp_prs [COLS];
    ev_t           ev_log [$];
    vec_t          vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h at n=%0d", name, act, req, n);
        end
    endtask

    function automatic int t_ev(input int f, input int r, input int c);
        return f*FP + r*RP + SETTLE + 1 + c;
    endfunction

    // One clock: advance the frame clock, run the frame-level model and compare every output.
    task automatic tick();
        int ph, row, w, k;
        logic [ROWS-1:0] exp_row;
        bit e;
        @(negedge clk);
        if (i_rst) begin
            n = -1;
            mstable = '0;
            for (int i = 0; i < NK; i++) mrun[i] = 0;
            for (int i = 0; i < COLS; i++) begin exp_evt[i] = 0; exp_prs[i] = 0; end
        end else begin
            n++;
            ph  = n % FP;
            row = ph / RP;
            w   = ph % RP;
            exp_row = (w <= SETTLE) ? ~(6'b000001 << row) : 6'b111111;
            chk("row_drive", 64'(gpio_row), 64'(exp_row));
            if (w == SETTLE) begin
                for (int c = 0; c < COLS; c++) begin
                    k = row*COLS + c;
                    exp_evt[c] = 0;
                    if (contacts[k] == mstable[k]) begin
                        mrun[k] = 0;
                    end else begin
                        mrun[k]++;
                        if (mrun[k] == DEB) begin
                            mstable[k] = contacts[k];
                            mrun[k] = 0;
                            exp_evt[c] = 1;
                            exp_prs[c] = contacts[k];
                        end
                    end
                end
            end
            e = (w > SETTLE) && exp_evt[w-SETTLE-1];
            chk("key_event", 64'(key_event), 64'(e));
            if (e) begin
                chk("key_index", 64'(key_index), 64'(row*COLS + w - SETTLE - 1));
                chk("key_press", 64'(key_press), 64'(exp_prs[w-SETTLE-1]));
            end
            chk("scan_done", 64'(scan_done), 64'(row == ROWS-1 && w == RP-1));
            if (w == SETTLE + 1) chk("sound_number", 64'(sound), 64'(mstable));
        end
        if (key_event === 1'b1) ev_log.push_back('{n, int'(key_index), key_press});
    endtask

    task automatic wait_n(input int target);
        for (int i = 0; i < 20*FP && n < target; i++) tick();
        if (n < target) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=%0d required=%0d", n, target);
        end
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        force_en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            force_val = COLS'($urandom);
            tick();
            chk("rst_row", 64'(gpio_row), 64'h3f);
            chk("rst_sound", 64'(sound), 64'h0);
            chk("rst_event", 64'(key_event), 64'h0);
            chk("rst_index", 64'(key_index), 64'h0);
            chk("rst_press", 64'(key_press), 64'h0);
            chk("rst_done", 64'(scan_done), 64'h0);
        end
        i_rst = 1'b0;
        force_en = 1'b0;
    endtask

    task automatic chk_event(input string name, input int base, input int idx, input bit press, input int t);
        chk({name, "_count"}, 64'(ev_log.size() - base), 64'd1);
        if (ev_log.size() > base) begin
            chk({name, "_index"}, 64'(ev_log[base].idx), 64'(idx));
            chk({name, "_press"}, 64'(ev_log[base].press), 64'(press));
            chk({name, "_cycle"}, 64'(ev_log[base].t), 64'(t));
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{2, 3, 6'd15, 36'h000008000};
        vecs[1] = '{0, 0, 6'd0,  36'h000000001};
        vecs[2] = '{5, 5, 6'd35, 36'h800000000};
        vecs[3] = '{4, 2, 6'd26, 36'h004000000};

        // Reset values, first row drive and row stepping.
        contacts = '0;
        do_reset(3);
        tick();
        chk("first_row", 64'(gpio_row), 64'h3e);
        wait_n(RP);
        chk("second_row", 64'(gpio_row), 64'h3d);

        // Single press then release of each table key.
        foreach (vecs[v]) begin
            contacts = '0;
            do_reset(3);
            base = ev_log.size();
            wait_n(5);
            contacts = NK'(1) << (vecs[v].r*COLS + vecs[v].c);
            wait_n(5*FP + 5);
            chk_event("press", base, int'(vecs[v].idx), 1'b1, t_ev(3, vecs[v].r, vecs[v].c));
            chk("press_bitmap", 64'(sound), 64'(vecs[v].bitmap));
            base = ev_log.size();
            contacts = '0;
            wait_n(10*FP + 5);
            chk_event("release", base, int'(vecs[v].idx), 1'b0, t_ev(8, vecs[v].r, vecs[v].c));
            chk("release_bitmap", 64'(sound), 64'h0);
        end

        // Bouncing contact on key 15: present/absent alternating for 6 frames, then present.
        contacts = '0;
        do_reset(3);
        base = ev_log.size();
        for (int f = 0; f < 12; f++) begin
            wait_n(f*FP + 5);
            contacts = (f >= 6 || f % 2 == 0) ? NK'(1) << 15 : '0;
        end
        chk_event("bounce", base, 15, 1'b1, t_ev(9, 2, 3));

        // Two keys of row 1 pressed together.
        contacts = '0;
        do_reset(3);
        base = ev_log.size();
        wait_n(5);
        contacts = (NK'(1) << 6) | (NK'(1) << 11);
        wait_n(5*FP + 5);
        chk("simul_count", 64'(ev_log.size() - base), 64'd2);
        if (ev_log.size() >= base + 2) begin
            chk("simul_idx0", 64'(ev_log[base].idx), 64'd6);
            chk("simul_idx1", 64'(ev_log[base+1].idx), 64'd11);
            chk("simul_prs", 64'({ev_log[base].press, ev_log[base+1].press}), 64'b11);
            chk("simul_gap", 64'(ev_log[base+1].t - ev_log[base].t), 64'd5);
            chk("simul_cycle", 64'(ev_log[base].t), 64'(t_ev(3, 1, 0)));
        end

        // Reset during a REPORT window while key 15 is held.
        contacts = '0;
        do_reset(3);
        wait_n(5);
        contacts = NK'(1) << 15;
        wait_n(4*FP + 2*RP + SETTLE + 2);
        chk("midrst_held", 64'(sound[15]), 64'd1);
        base = ev_log.size();
        do_reset(2);
        wait_n(5*FP + 5);
        chk_event("midrst_redetect", base, 15, 1'b1, t_ev(3, 2, 3));

        // Random walk of contacts, one flip opportunity per key per frame.
        contacts = '0;
        do_reset(3);
        for (int f = 0; f < 16; f++) begin
            wait_n(f*FP + 5);
            for (int k = 0; k < NK; k++)
                if ($urandom_range(7, 0) == 0) contacts[k] = ~contacts[k];
        end
        wait_n(16*FP + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Active scanner for the 6×6 sound-key matrix on the GPIO header. It drives one row line low at a time and samples the column lines through a synchronizer. Each of the 36 keys is debounced over several full scans. Outputs are a level bitmap of held keys (same index layout as the existing sound-number bus) and a serialized press/release event stream for the sound engine.

## Interface
- `ROWS`, 6, number of row drive lines
- `COLS`, 6, number of column sense lines
- `SETTLE_CYCLES`, 64, cycles a row is driven before sampling; must be ≥ 3
- `DEBOUNCE_SCANS`, 4, consecutive identical samples required to change a key's state; must be ≥ 1
- `i_clk`, in, 1, system clock
- `i_rst`, in, 1, reset (one clock; reset is synchronous and active-high)
- `o_GPIO_ROW`, out, ROWS, row drive, active-low, registered; at most one bit low at any time
- `i_GPIO_COL`, in, COLS, column sense, active-low (board pull-ups), asynchronous
- `o_sound_number`, out, ROWS*COLS, debounced held-key bitmap; bit r*COLS+c = key (row r, col c)
- `o_key_event`, out, 1, one-cycle pulse: a key changed debounced state
- `o_key_index`, out, 6, key index r*COLS+c of the current event; valid only while `o_key_event`=1
- `o_key_press`, out, 1, 1 = press, 0 = release; valid only while `o_key_event`=1
- `o_scan_done`, out, 1, one-cycle pulse at the end of the REPORT phase of row ROWS-1

## Operation
- Column input passes through a 2-flop synchronizer, then is inverted: raw[c] = ~sync[c].
- Per-key state: stable bit (this is `o_sound_number`), counter cnt (width $clog2(DEBOUNCE_SCANS+1)), and changed flag.
- FSM:
  - SETTLE: drive row r low; count SETTLE_CYCLES cycles; then go to SAMPLE.
  - SAMPLE: one cycle, row r still low. For each column c of row r:
    - raw == stable: cnt←0, changed←0.
    - raw ≠ stable and cnt+1 == DEBOUNCE_SCANS: stable←raw, cnt←0, changed←1.
    - otherwise: cnt←cnt+1, changed←0.
    - Then go to REPORT.
  - REPORT: COLS cycles with all rows high. In cycle c, if changed[c] is set: `o_key_event`=1, `o_key_index`=r*COLS+c, `o_key_press`=stable. After the last cycle: r←(r+1) mod ROWS, go to SETTLE. `o_scan_done` pulses with the last REPORT cycle when r = ROWS-1.
- Events from one row come out in ascending column order, one per cycle, so no event is lost when several keys in a row change at once.
- No ghost/anti-masking logic; a 3-key rectangle may report a phantom fourth key.
- Index arithmetic: r*COLS+c fits in 6 bits for ROWS*COLS ≤ 64. Row wrap is from ROWS-1 to 0.
- Reset (any state, any time): clears all stable bits, counters and changed flags, and sets r=0, state=SETTLE with count 0. No release events are emitted for keys held at reset. The synchronizer is also cleared to all-ones (idle).

## Timing
- Reset values: `o_GPIO_ROW`=all ones; `o_sound_number`=0; `o_key_event`=0; `o_key_index`=0; `o_key_press`=0; `o_scan_done`=0.
- In the first cycle after `i_rst` deasserts, `o_GPIO_ROW`=~(1<<0).
- Row period = SETTLE_CYCLES + 1 + COLS cycles (71 by default). Frame = ROWS × row period (426 by default).
- SAMPLE uses sync data captured at least SETTLE_CYCLES-2 cycles after the row went low.
- `o_sound_number` bit updates in the cycle after SAMPLE. This is the same cycle as REPORT cycle 0.
- The event for column c appears c+1 cycles after SAMPLE. `o_key_index`/`o_key_press` are registered and stable for that cycle.
- Press latency: DEBOUNCE_SCANS frames worst case from a stable contact, plus up to one frame of alignment.
- The counter for a key advances once per frame, only at its own row's SAMPLE.

## Test plan
- Reset: hold `i_rst` 3 cycles with random columns. Required: all outputs at reset values, `o_GPIO_ROW`=6'b111111. First cycle after release: 6'b111110. Row 1 goes low 71 cycles later.
- Single press: matrix model shorts row 2 to col 3 continuously. Required: exactly one event (index 15, press=1) in the 4th frame; `o_sound_number`=36'h000008000; no other events.
- Bounce: contact at (2,3) alternates present/absent on successive frames for 6 frames, then stays present. Required: no event during the alternation; press event index 15 on the 4th consecutive present sample.
- Simultaneous: keys (1,0) and (1,5) pressed together. Required: events index 6 and index 11 in the same REPORT window, 5 cycles apart, both press=1.
- Release: after the single press, remove the contact. Required: one event (index 15, press=0) after 4 frames; bit 15 clears the same cycle as REPORT cycle 0.
- Reset mid-operation: assert `i_rst` during REPORT while key 15 is held. Required: `o_sound_number`=0 and no release event; press event is re-detected after 4 frames.
